// File: rtl/elevator_ctrl.sv
// elevator_ctrl: four-floor elevator controller.
// Hall and cab calls latch into pending registers; a three-state FSM
// (IDLE / MOVE / DOOR) moves the car in half-floor steps, keeps travelling
// in one direction while calls remain ahead, and holds the door open for
// DOOR_CYCLES cycles at each stop. All outputs are registered.
module elevator_ctrl #(
  parameter int unsigned DOOR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] button_up,
  input  logic [2:0] button_down,
  input  logic [3:0] button_in,
  output logic [2:0] position,
  output logic       open,
  output logic [1:0] direction
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  localparam logic [1:0] DIR_IDLE  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DN    = 2'b10;
  localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES - 1);

  // Floors strictly above floor f.
  function automatic logic [3:0] above_mask(input logic [1:0] f);
    above_mask = 4'b1110 << f;
  endfunction

  // Floors strictly below floor f.
  function automatic logic [3:0] below_mask(input logic [1:0] f);
    below_mask = ~(4'b1111 << f);
  endfunction

  // Single-bit mask selecting floor f.
  function automatic logic [3:0] floor_mask(input logic [1:0] f);
    floor_mask = 4'b0001 << f;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic       open_q, open_d;
  logic [1:0] dir_q, dir_d;
  logic       last_up_q, last_up_d;
  logic [3:0] cnt_q, cnt_d;
  // Pending calls indexed by floor. up_q[3] and dn_q[0] have no button
  // and stay zero; keeping all vectors 4 wide keeps the floor logic uniform.
  logic [3:0] up_q, up_d;
  logic [3:0] dn_q, dn_d;
  logic [3:0] cab_q, cab_d;

  logic [3:0] any_s;
  logic [1:0] cur_f_s;
  logic       cur_above_s, cur_below_s;
  logic [2:0] step_pos_s;
  logic [1:0] stop_f_s;
  logic       stop_above_s, stop_below_s;
  logic       stop_hit_s;

  logic [3:0] clr_up_s, clr_dn_s, clr_cab_s;
  logic [3:0] abs_up_s, abs_dn_s, abs_cab_s;

  assign any_s        = up_q | dn_q | cab_q;
  assign cur_f_s      = pos_q[2:1];
  assign cur_above_s  = |(any_s & above_mask(cur_f_s));
  assign cur_below_s  = |(any_s & below_mask(cur_f_s));
  assign step_pos_s   = (dir_q == DIR_DN) ? (pos_q - 3'd1) : (pos_q + 3'd1);
  assign stop_f_s     = step_pos_s[2:1];
  assign stop_above_s = |(any_s & above_mask(stop_f_s));
  assign stop_below_s = |(any_s & below_mask(stop_f_s));

  // Decide whether the step about to be taken lands on a floor we must serve.
  always_comb begin
    stop_hit_s = 1'b0;
    if (step_pos_s[0] == 1'b0) begin
      if (dir_q == DIR_DN) begin
        stop_hit_s = cab_q[stop_f_s] | dn_q[stop_f_s] | ~stop_below_s;
      end else begin
        stop_hit_s = cab_q[stop_f_s] | up_q[stop_f_s] | ~stop_above_s;
      end
    end else begin
      stop_hit_s = 1'b0;
    end
  end

  // Next-state, output and pending-call update logic.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    open_d    = open_q;
    dir_d     = dir_q;
    last_up_d = last_up_q;
    cnt_d     = cnt_q;
    clr_up_s  = 4'b0000;
    clr_dn_s  = 4'b0000;
    clr_cab_s = 4'b0000;
    abs_up_s  = 4'b0000;
    abs_dn_s  = 4'b0000;
    abs_cab_s = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (any_s[cur_f_s]) begin
          // Call at this floor: open and serve everyone waiting here.
          state_d   = ST_DOOR;
          open_d    = 1'b1;
          dir_d     = DIR_IDLE;
          cnt_d     = DOOR_LOAD;
          clr_up_s  = floor_mask(cur_f_s);
          clr_dn_s  = floor_mask(cur_f_s);
          clr_cab_s = floor_mask(cur_f_s);
        end else if ((last_up_q && cur_above_s) || (!last_up_q && !cur_below_s && cur_above_s)) begin
          state_d   = ST_MOVE;
          dir_d     = DIR_UP;
          last_up_d = 1'b1;
          pos_d     = pos_q + 3'd1;
        end else if (cur_below_s) begin
          state_d   = ST_MOVE;
          dir_d     = DIR_DN;
          last_up_d = 1'b0;
          pos_d     = pos_q - 3'd1;
        end else begin
          dir_d = DIR_IDLE;
        end
      end

      ST_MOVE: begin
        pos_d = step_pos_s;
        if (stop_hit_s) begin
          state_d   = ST_DOOR;
          open_d    = 1'b1;
          cnt_d     = DOOR_LOAD;
          clr_cab_s = floor_mask(stop_f_s);
          if (dir_q == DIR_DN) begin
            clr_dn_s = floor_mask(stop_f_s);
            clr_up_s = stop_below_s ? 4'b0000 : floor_mask(stop_f_s);
          end else begin
            clr_up_s = floor_mask(stop_f_s);
            clr_dn_s = stop_above_s ? 4'b0000 : floor_mask(stop_f_s);
          end
        end else begin
          state_d = ST_MOVE;
        end
      end

      ST_DOOR: begin
        // Calls for this floor that the open door already serves are dropped.
        abs_cab_s = floor_mask(cur_f_s);
        abs_up_s  = (dir_q != DIR_DN) ? floor_mask(cur_f_s) : 4'b0000;
        abs_dn_s  = (dir_q != DIR_UP) ? floor_mask(cur_f_s) : 4'b0000;
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          open_d  = 1'b0;
          dir_d   = DIR_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        open_d  = 1'b0;
        dir_d   = DIR_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    up_d  = (up_q  & ~clr_up_s)  | ({1'b0, button_up}   & ~abs_up_s);
    dn_d  = (dn_q  & ~clr_dn_s)  | ({button_down, 1'b0} & ~abs_dn_s);
    cab_d = (cab_q & ~clr_cab_s) | (button_in           & ~abs_cab_s);
  end

  // State, outputs and pending calls; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pos_q     <= 3'd0;
      open_q    <= 1'b0;
      dir_q     <= DIR_IDLE;
      last_up_q <= 1'b1;
      cnt_q     <= 4'd0;
      up_q      <= 4'b0000;
      dn_q      <= 4'b0000;
      cab_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      open_q    <= open_d;
      dir_q     <= dir_d;
      last_up_q <= last_up_d;
      cnt_q     <= cnt_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      cab_q     <= cab_d;
    end
  end

  assign position  = pos_q;
  assign open      = open_q;
  assign direction = dir_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed, table-driven bench for elevator_ctrl
// (DOOR_CYCLES = 2). Each row drives one clock edge and gives the outputs
// expected just after that edge.
module tb_elevator_ctrl;

  logic       clk;
  logic       reset_n;
  logic [2:0] button_up;
  logic [2:0] button_down;
  logic [3:0] button_in;
  logic [2:0] position;
  logic       door_open;
  logic [1:0] direction;

  int n_checks;
  int n_fail;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [2:0] bu;
    logic [2:0] bd;
    logic [3:0] bi;
    logic [2:0] pos;
    logic       op;
    logic [1:0] dir;
  } vec_t;

  vec_t tbl[$];

  elevator_ctrl #(.DOOR_CYCLES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .button_up   (button_up),
    .button_down (button_down),
    .button_in   (button_in),
    .position    (position),
    .open        (door_open),
    .direction   (direction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one vector.
  function automatic void add(input string name, input logic rn, input logic [2:0] bu,
                              input logic [2:0] bd, input logic [3:0] bi,
                              input logic [2:0] pos, input logic op, input logic [1:0] dir);
    vec_t v;
    v.name = name; v.rst_n = rn; v.bu = bu; v.bd = bd; v.bi = bi;
    v.pos = pos; v.op = op; v.dir = dir;
    tbl.push_back(v);
  endfunction

  // Drive inputs at the falling edge, let one rising edge pass, then compare.
  task automatic step(input string name, input logic rn, input logic [2:0] bu,
                      input logic [2:0] bd, input logic [3:0] bi,
                      input logic [2:0] pos, input logic op, input logic [1:0] dir);
    @(negedge clk);
    reset_n     = rn;
    button_up   = bu;
    button_down = bd;
    button_in   = bi;
    @(posedge clk);
    #1;
    n_checks++;
    if (position !== pos || door_open !== op || direction !== dir) begin
      n_fail++;
      $display("FAIL %s: got pos=%0d open=%0b dir=%b, expected pos=%0d open=%0b dir=%b",
               name, position, door_open, direction, pos, op, dir);
    end
    n_checks++;
    if (direction === 2'b11 || (door_open === 1'b1 && position[0] === 1'b1)) begin
      n_fail++;
      $display("FAIL %s_invariant: got pos=%0d open=%0b dir=%b, expected even pos when open and dir!=11",
               name, position, door_open, direction);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    button_up   = 3'b000;
    button_down = 3'b000;
    button_in   = 4'b0000;

    // ---------------- table: reset, cab to floor 2, idle reopen, hall/cab tests
    add("rst0",     1'b0, 3'b000, 3'b000, 4'b1111, 3'd0, 1'b0, 2'b00);
    add("rst1",     1'b0, 3'b111, 3'b111, 4'b0000, 3'd0, 1'b0, 2'b00);
    // Cab call to floor 2 from floor 0.
    add("c2_k",     1'b1, 3'b000, 3'b000, 4'b0100, 3'd0, 1'b0, 2'b00);
    add("c2_k1",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd1, 1'b0, 2'b01);
    add("c2_k2",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd2, 1'b0, 2'b01);
    add("c2_k3",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd3, 1'b0, 2'b01);
    add("c2_k4",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b1, 2'b01);
    // Down call at floor 2 while door serves upward travel: latches.
    add("c2_k5",    1'b1, 3'b000, 3'b010, 4'b0000, 3'd4, 1'b1, 2'b01);
    add("c2_k6",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b0, 2'b00);
    add("dn2_open", 1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b1, 2'b00);
    add("dn2_hold", 1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b1, 2'b00);
    add("dn2_shut", 1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b0, 2'b00);
    // Reset from floor 2 returns the car to floor 0.
    add("rst_fl2",  1'b0, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    // Hall up at floor 0; cab 0 during door is absorbed.
    add("u0_k",     1'b1, 3'b001, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    add("u0_k1",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b1, 2'b00);
    add("u0_k2",    1'b1, 3'b000, 3'b000, 4'b0001, 3'd0, 1'b1, 2'b00);
    add("u0_k3",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    add("u0_k4",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    add("u0_k5",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    // Cab 3 then hall down at floor 2: passes floor 2, serves it on the way back.
    add("p_k",      1'b1, 3'b000, 3'b000, 4'b1000, 3'd0, 1'b0, 2'b00);
    add("p_k1",     1'b1, 3'b000, 3'b010, 4'b0000, 3'd1, 1'b0, 2'b01);
    add("p_k2",     1'b1, 3'b000, 3'b000, 4'b0000, 3'd2, 1'b0, 2'b01);
    add("p_k3",     1'b1, 3'b000, 3'b000, 4'b0000, 3'd3, 1'b0, 2'b01);
    add("p_k4",     1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b0, 2'b01);
    add("p_k5",     1'b1, 3'b000, 3'b000, 4'b0000, 3'd5, 1'b0, 2'b01);
    add("p_k6",     1'b1, 3'b000, 3'b000, 4'b0000, 3'd6, 1'b1, 2'b01);
    add("p_k7",     1'b1, 3'b000, 3'b000, 4'b0000, 3'd6, 1'b1, 2'b01);
    add("p_k8",     1'b1, 3'b000, 3'b000, 4'b0000, 3'd6, 1'b0, 2'b00);
    add("p_k9",     1'b1, 3'b000, 3'b000, 4'b0000, 3'd5, 1'b0, 2'b10);
    add("p_k10",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b1, 2'b10);
    add("p_k11",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b1, 2'b10);
    add("p_k12",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b0, 2'b00);
    add("p_k13",    1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b0, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].name, tbl[i].rst_n, tbl[i].bu, tbl[i].bd, tbl[i].bi,
           tbl[i].pos, tbl[i].op, tbl[i].dir);
    end

    // ---------------- sequence: reset then 20 quiet cycles stay idle at floor 0
    step("q_rst", 1'b0, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      step("quiet", 1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    end

    // ---------------- sequence: reset while moving cancels everything
    step("m_k",    1'b1, 3'b000, 3'b000, 4'b0100, 3'd0, 1'b0, 2'b00);
    step("m_k1",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd1, 1'b0, 2'b01);
    step("m_rst",  1'b0, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      step("m_still", 1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    end

    // ---------------- sequence: from floor 1, calls at 3 and 0 -> up first
    step("f1_k0",  1'b1, 3'b000, 3'b000, 4'b0010, 3'd0, 1'b0, 2'b00);
    step("f1_k1",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd1, 1'b0, 2'b01);
    step("f1_k2",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd2, 1'b1, 2'b01);
    step("f1_k3",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd2, 1'b1, 2'b01);
    step("f1_k4",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd2, 1'b0, 2'b00);
    step("b_k",    1'b1, 3'b000, 3'b000, 4'b1001, 3'd2, 1'b0, 2'b00);
    step("b_k1",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd3, 1'b0, 2'b01);
    step("b_k2",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b0, 2'b01);
    step("b_k3",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd5, 1'b0, 2'b01);
    step("b_k4",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd6, 1'b1, 2'b01);
    step("b_k5",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd6, 1'b1, 2'b01);
    step("b_k6",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd6, 1'b0, 2'b00);
    step("b_k7",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd5, 1'b0, 2'b10);
    step("b_k8",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd4, 1'b0, 2'b10);
    step("b_k9",   1'b1, 3'b000, 3'b000, 4'b0000, 3'd3, 1'b0, 2'b10);
    step("b_k10",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd2, 1'b0, 2'b10);
    step("b_k11",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd1, 1'b0, 2'b10);
    step("b_k12",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b1, 2'b10);
    step("b_k13",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b1, 2'b10);
    step("b_k14",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);
    step("b_k15",  1'b1, 3'b000, 3'b000, 4'b0000, 3'd0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 SHALL have parameter DOOR_CYCLES, default 2, meaning the number of clock cycles open stays high per stop (legal range 1..15).
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port button_up  input  3  hall up-call; bit i = floor i (floors 0..2).
REQ-005 SHALL have port button_down  input  3  hall down-call; bit i = floor i+1 (floors 1..3).
REQ-006 SHALL have port button_in  input  4  cab call; bit i = floor i (floors 0..3).
REQ-007 SHALL have port position  output  3  car location; 2*f at floor f, odd value between floors (legal 0..6).
REQ-008 SHALL have port open  output  1  door open.
REQ-009 SHALL have port direction  output  2  00 idle, 01 up, 10 down; 11 never driven.

Function
REQ-010 SHALL OR every input bit sampled at a rising edge into pending registers (up[0..2], down[1..3], cab[0..3]); pending holds until cleared by a stop; FSM decisions use pending only (one-cycle request latency).
REQ-011 SHALL implement states IDLE, MOVE, DOOR; all outputs registered.
REQ-012 IDLE: pending at current floor -> DOOR, open<=1, direction<=00, clear all pending at that floor; else pending in last-travel direction -> MOVE in that direction; else pending on other side -> MOVE reversed; else stay, direction=00.
REQ-013 Entering MOVE SHALL update direction and step position by one on the same edge.
REQ-014 MOVE: each edge position steps +1 (up) or -1 (down); position SHALL never leave 0..6.
REQ-015 Stop rule on the edge position becomes 2*f: up -> stop if cab[f] or up[f] or no pending above f; down -> stop if cab[f] or down[f] or no pending below f.
REQ-016 On stop edge: state<=DOOR, open<=1, direction unchanged, clear cab[f] and hall call at f in travel direction; also clear opposite hall call at f if no pending beyond f in travel direction.
REQ-017 DOOR: open SHALL stay high exactly DOOR_CYCLES cycles; on expiry edge open<=0, direction<=00, state<=IDLE (last-travel direction retained internally).
REQ-018 Calls at current floor arriving during DOOR (cab, or hall in served direction) SHALL be absorbed (cleared, door time not extended); other calls latch normally.
REQ-019 Simultaneous calls SHALL all latch; floors passed mid-travel without a matching stop rule SHALL keep their calls pending.
REQ-020 open and position SHALL never change on the same edge except on stop edge; open=1 only when position is even.

Reset
REQ-021 reset_n low at a rising edge SHALL force position=0, open=0, direction=00, state IDLE, last-travel=up, all pending cleared, door counter 0, regardless of state (including mid-move or door open).
REQ-022 Inputs sampled during reset SHALL be ignored.

Verification (DOOR_CYCLES=2; k = edge where input first sampled high, held one cycle)
REQ-023 Reset release -> position=0, open=0, direction=00 until a call; no-call run of 20 cycles -> outputs unchanged.
REQ-024 Idle floor 0, button_in=0100 -> k+1 pos1 dir01; k+2 pos2; k+3 pos3; k+4 pos4 open1 dir01; k+5 open1; k+6 open0 dir00 pos4.
REQ-025 Idle floor 0, button_up=001 -> k+1 open1 dir00 pos0; k+3 open0; cab press 0001 at k+2 absorbed, no reopen.
REQ-026 Idle floor 0, button_in=1000 at k, button_down=010 (floor 2) at k+1 -> no stop at pos4; k+6 pos6 open1 dir01; k+8 open0 dir00; k+9 pos5 dir10; k+10 pos4 open1 dir10; k+12 open0 dir00.
REQ-027 Reset asserted at k+2 of REQ-024 scenario -> next edge pos0 open0 dir00, pending empty, no motion afterward.
REQ-028 Idle floor 1 (pos2), button_in=1001 at k -> k+1 pos3 dir01 (last-travel up preferred), stop at pos6, then serve floor 0 descending.
